serial_frame_tx: RTL and testbench
==================================

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter N, default 8, data word width in bits (N >= 2).
REQ-002 Parameter BAUD_DIV, default 4, clock cycles each serial bit is held (BAUD_DIV >= 1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 data_in  input  N  parallel word to transmit.
REQ-006 valid_in  input  1  requester has a word on data_in.
REQ-007 ready_out  output  1  block accepts a word this cycle.
REQ-008 SO  output  1  serial line, idles high.
REQ-009 busy  output  1  frame in progress.
REQ-010 done  output  1  one-cycle pulse, frame complete.

Function
REQ-011 The block SHALL transmit each accepted word as a frame in this order: start bit (0), data bits LSB first, optional parity bit, stop bit (1).
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, with PARITY reachable only when parity is compiled in.
REQ-013 Transitions SHALL be IDLE->START on accept, START->DATA after BAUD_DIV cycles, DATA->PARITY or STOP after N bits, PARITY->STOP after BAUD_DIV cycles, and STOP->IDLE after BAUD_DIV cycles.
REQ-014 ready_out SHALL be high only in IDLE; acceptance is the cycle where valid_in && ready_out.
REQ-015 data_in SHALL be captured into an internal N-bit parallel-load shift register on the accept edge; later changes to data_in SHALL NOT affect the frame.
REQ-016 SO SHALL drive the start bit from the cycle after acceptance, giving 1 cycle latency.
REQ-017 Every bit SHALL be held exactly BAUD_DIV cycles, counted by a divider counter of width $clog2(BAUD_DIV+1) that wraps to 0 at each bit boundary.
REQ-018 In DATA, the shift register SHALL right-shift one position at each bit boundary, and SO SHALL equal the register LSB.
REQ-019 A bit counter of width $clog2(N+1) SHALL count data bits, and DATA SHALL exit exactly when it reaches N-1 at a bit boundary.
REQ-020 Total frame length SHALL be (N+2)*BAUD_DIV cycles, or (N+3)*BAUD_DIV cycles with parity.
REQ-021 busy SHALL be high in every state except IDLE.
REQ-022 done SHALL pulse high for the last cycle of STOP only.
REQ-023 valid_in while busy SHALL be ignored, with no queuing.
REQ-024 Back-to-back transfer: after done, the block SHALL be in IDLE with ready_out high in the next cycle, so the minimum gap between frames is one idle-high cycle.
REQ-025 With BAUD_DIV=1, each bit SHALL last exactly one cycle, with no skipped or repeated bit.

Reset
REQ-026 On reset_n low at a rising edge, the block SHALL enter IDLE, clear all counters and the shift register, and set SO=1, ready_out=1, busy=0, done=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame, return SO high on the next edge, and produce no done pulse.
REQ-028 valid_in in the cycle reset_n is low SHALL NOT be accepted.

Configuration
REQ-029 Macro SERIAL_TX_PARITY_EN: when defined, the PARITY state SHALL send the even-parity bit (XOR of all N data bits) for BAUD_DIV cycles.
REQ-030 Without SERIAL_TX_PARITY_EN, the PARITY state and parity logic SHALL be absent, and DATA SHALL go directly to STOP.

Structure
REQ-031 Package serial_tx_pkg SHALL hold the FSM state enum typedef and the start/stop/idle level constants.
REQ-032 The shift register SHALL be one sub-module, piso_shift_reg, providing parallel load, right shift, and LSB output, driven by load/shift enables from the FSM.

Verification
REQ-033 N=8, BAUD_DIV=4, send 0xA5 -> SO = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; done pulses in cycle 40 after accept; busy high for 40 cycles.
REQ-034 With SERIAL_TX_PARITY_EN, send 0xA5 then 0x07 -> parity bits 0 then 1; each frame is 44 cycles.
REQ-035 Hold valid_in high with 0x3C then 0xC3 -> second accept exactly 1 cycle after the first done; one idle-high cycle between frames.
REQ-036 Pulse valid_in with 0xFF during the DATA state of a 0x00 frame -> ignored; frame stays all-zero data; no extra frame.
REQ-037 Assert reset_n low in cycle 15 of a frame -> next edge gives SO=1, busy=0, ready_out=1; no done pulse.
REQ-038 BAUD_DIV=1, send 0x81 -> SO = 0,1,0,0,0,0,0,0,1,1 on consecutive cycles; done in cycle 10.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared FSM state encoding and serial line levels for the frame transmitter.
// PARITY exists only when SERIAL_TX_PARITY_EN is defined.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SERIAL_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_t;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register: load wins over shift, shifts right, LSB out.
// Latency: one cycle from load/shift to the new lsb value.
module piso_shift_reg #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] data,
    output logic         lsb
);

    logic [N-1:0] q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= data;
        end else if (shift) begin
            q <= {1'b0, q[N-1:1]};
        end
    end

    assign lsb = q[0];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start, N data bits LSB first, optional parity (SERIAL_TX_PARITY_EN), stop.
// Latency: start bit on SO the cycle after accept; each bit held BAUD_DIV cycles.
// Backpressure: ready_out high only in IDLE; valid_in while busy is dropped, never queued.
module serial_frame_tx
    import serial_tx_pkg::*;
#(
    parameter int N        = 8,
    parameter int BAUD_DIV = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] data_in,
    input  logic         valid_in,
    output logic         ready_out,
    output logic         SO,
    output logic         busy,
    output logic         done
);

    localparam int DW = $clog2(BAUD_DIV + 1);
    localparam int BW = $clog2(N + 1);

    tx_state_t     state;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic          line_q;
    logic          sr_lsb;

    logic          accept;
    logic          bit_end;
    logic [DW-1:0] div_nxt;

    assign accept  = valid_in && ready_out;
    assign bit_end = (div_cnt == DW'(BAUD_DIV - 1));
    assign div_nxt = div_cnt + 1'b1;

    piso_shift_reg #(.N(N)) u_sr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept),
        .shift   ((state == DATA) && bit_end),
        .data    (data_in),
        .lsb     (sr_lsb)
    );

`ifdef SERIAL_TX_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^data_in;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            line_q    <= IDLE_LVL;
            ready_out <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= START;
                        line_q    <= START_LVL;
                        ready_out <= 1'b0;
                        busy      <= 1'b1;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        state   <= DATA;
                    end else begin
                        div_cnt <= div_nxt;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (bit_cnt == BW'(N - 1)) begin
                            bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
                            state   <= PARITY;
                            line_q  <= par_q;
`else
                            state   <= STOP;
                            line_q  <= STOP_LVL;
                            done    <= (BAUD_DIV == 1);
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_nxt;
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        state   <= STOP;
                        line_q  <= STOP_LVL;
                        done    <= (BAUD_DIV == 1);
                    end else begin
                        div_cnt <= div_nxt;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        div_cnt   <= '0;
                        state     <= IDLE;
                        line_q    <= IDLE_LVL;
                        ready_out <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        // done is registered, so raise it one cycle ahead of the final STOP cycle
                        div_cnt <= div_nxt;
                        done    <= (div_nxt == DW'(BAUD_DIV - 1));
                    end
                end
                default: begin
                    state     <= IDLE;
                    line_q    <= IDLE_LVL;
                    ready_out <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // data bits come straight from the shift register; all other bits from the line level flop
    assign SO = (state == DATA) ? sr_lsb : line_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: BAUD_DIV=4 instance for framing/flow/reset, BAUD_DIV=1 instance for single-cycle bits.
module tb_serial_frame_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FLA = NB * 4;
    localparam int FLB = NB;

    logic       clk = 1'b0;
    logic       rst_a_n, valid_a, rdy_a, so_a, busy_a, done_a;
    logic       rst_b_n, valid_b, rdy_b, so_b, busy_b, done_b;
    logic [7:0] data_a, data_b;

    int errors = 0;
    int checks = 0;

    logic [127:0] so_v, busy_v, done_v, rdy_v;

    always #5 clk = ~clk;

    serial_frame_tx #(.N(8), .BAUD_DIV(4)) dut_a (
        .clk       (clk),
        .reset_n   (rst_a_n),
        .data_in   (data_a),
        .valid_in  (valid_a),
        .ready_out (rdy_a),
        .SO        (so_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    serial_frame_tx #(.N(8), .BAUD_DIV(1)) dut_b (
        .clk       (clk),
        .reset_n   (rst_b_n),
        .data_in   (data_b),
        .valid_in  (valid_b),
        .ready_out (rdy_b),
        .SO        (so_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] ones(input int n);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [127:0] bit_at(input int n);
        logic [127:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    // Expected SO per cycle after accept, bit 0 = first cycle of the frame.
    function automatic logic [127:0] exp_so(input logic [7:0] d, input int bd);
        logic [10:0]  b;
        logic [127:0] v;
        b    = '0;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = d[i];
`ifdef SERIAL_TX_PARITY_EN
        b[9]  = ($countones(d) % 2) == 1;
        b[10] = 1'b1;
`else
        b[9]  = 1'b1;
`endif
        v = '0;
        for (int c = 0; c < NB * bd; c++) v[c] = b[c / bd];
        return v;
    endfunction

    task automatic kick(input bit sel, input logic [7:0] d);
        if (sel) begin
            chk("rdy_before_b", rdy_b, 1);
            data_b  = d;
            valid_b = 1'b1;
        end else begin
            chk("rdy_before_a", rdy_a, 1);
            data_a  = d;
            valid_a = 1'b1;
        end
        step();
    endtask

    task automatic record(input bit sel, input int ncyc, input logic [7:0] d_next,
                          input int hold_until, input int pulse_at, input int rst_at,
                          output logic [127:0] so_o, output logic [127:0] busy_o,
                          output logic [127:0] done_o, output logic [127:0] rdy_o);
        so_o = '0; busy_o = '0; done_o = '0; rdy_o = '0;
        for (int c = 0; c < ncyc; c++) begin
            so_o[c]   = sel ? so_b   : so_a;
            busy_o[c] = sel ? busy_b : busy_a;
            done_o[c] = sel ? done_b : done_a;
            rdy_o[c]  = sel ? rdy_b  : rdy_a;
            if (sel) begin
                valid_b = (c < hold_until) || (c == pulse_at);
                if (c == 0) data_b = d_next;
                rst_b_n = (c != rst_at);
            end else begin
                valid_a = (c < hold_until) || (c == pulse_at);
                if (c == 0) data_a = d_next;
                rst_a_n = (c != rst_at);
            end
            step();
        end
    endtask

    task automatic frame_chk(input string tag, input logic [127:0] e_so, input logic [127:0] e_busy,
                             input logic [127:0] e_done, input logic [127:0] e_rdy);
        chk({tag, "_so"},   so_v,   e_so);
        chk({tag, "_busy"}, busy_v, e_busy);
        chk({tag, "_done"}, done_v, e_done);
        chk({tag, "_rdy"},  rdy_v,  e_rdy);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        valid_a = 1'b1; valid_b = 1'b1;
        data_a  = 8'hFF; data_b = 8'hFF;
        repeat (3) step();
        chk("rst_a", {so_a, rdy_a, busy_a, done_a}, 4'b1100);
        chk("rst_b", {so_b, rdy_b, busy_b, done_b}, 4'b1100);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        step();
        chk("no_acc_rst_a", {so_a, rdy_a, busy_a, done_a}, 4'b1100);
        chk("no_acc_rst_b", {so_b, rdy_b, busy_b, done_b}, 4'b1100);

        // 0xA5: data input changed right after accept must not disturb the frame
        kick(0, 8'hA5);
        record(0, FLA + 1, 8'h5A, 0, -1, -1, so_v, busy_v, done_v, rdy_v);
        frame_chk("a5", exp_so(8'hA5, 4) | bit_at(FLA), ones(FLA), bit_at(FLA - 1), bit_at(FLA));

        kick(0, 8'h07);
        record(0, FLA + 1, 8'h00, 0, -1, -1, so_v, busy_v, done_v, rdy_v);
        frame_chk("x07", exp_so(8'h07, 4) | bit_at(FLA), ones(FLA), bit_at(FLA - 1), bit_at(FLA));

        // valid held: second accept in the single idle cycle after the first done
        kick(0, 8'h3C);
        record(0, 2 * FLA + 1, 8'hC3, FLA + 1, -1, -1, so_v, busy_v, done_v, rdy_v);
        frame_chk("b2b",
                  exp_so(8'h3C, 4) | bit_at(FLA) | (exp_so(8'hC3, 4) << (FLA + 1)),
                  ones(FLA) | (ones(FLA) << (FLA + 1)),
                  bit_at(FLA - 1) | bit_at(2 * FLA),
                  bit_at(FLA));

        // 0xFF pulse during DATA of a 0x00 frame is dropped
        kick(0, 8'h00);
        record(0, FLA + 3, 8'hFF, 0, 12, -1, so_v, busy_v, done_v, rdy_v);
        frame_chk("ign", exp_so(8'h00, 4) | (ones(3) << FLA), ones(FLA), bit_at(FLA - 1), ones(3) << FLA);

        // reset low in cycle 15 of the frame aborts it
        kick(0, 8'hA5);
        record(0, FLA + 2, 8'h5A, 0, -1, 14, so_v, busy_v, done_v, rdy_v);
        frame_chk("abort",
                  (exp_so(8'hA5, 4) & ones(15)) | (ones(FLA + 2) & ~ones(15)),
                  ones(15),
                  128'd0,
                  ones(FLA + 2) & ~ones(15));

        // BAUD_DIV=1: one cycle per bit
        kick(1, 8'h81);
        record(1, FLB + 1, 8'h7E, 0, -1, -1, so_v, busy_v, done_v, rdy_v);
        frame_chk("bd1", exp_so(8'h81, 1) | bit_at(FLB), ones(FLB), bit_at(FLB - 1), bit_at(FLB));
`ifndef SERIAL_TX_PARITY_EN
        chk("bd1_lit", so_v[9:0], 10'b11_0000_0010);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
